// File: rtl/comp_decomp_pkg.sv
// comp_decomp_pkg: shared command/response encodings and default widths for the dictionary codec.
package comp_decomp_pkg;
    localparam int DATA_W = 80;
    localparam int ADDR_W = 8;
    typedef enum logic [1:0] {CMD_NOP, CMD_COMPRESS, CMD_DECOMPRESS, CMD_RSVD} command_e;
    typedef enum logic [1:0] {RESP_IDLE, RESP_COMP_OK, RESP_DECOMP_OK, RESP_ERROR} response_e;
endpackage

// File: rtl/comp_if.sv
// comp_if: command/operand/result bundle between a host (master) and the codec (slave).
interface comp_if #(
    parameter int ADDR_W = comp_decomp_pkg::ADDR_W,
    parameter int DATA_W = comp_decomp_pkg::DATA_W
);
    logic [1:0]        command;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] compressed_in;
    logic [ADDR_W-1:0] compressed_out;
    logic [DATA_W-1:0] decompressed_out;
    logic [1:0]        response;
    modport master (output command, data_in, compressed_in, input compressed_out, decompressed_out, response);
    modport slave (input command, data_in, compressed_in, output compressed_out, decompressed_out, response);
endinterface

// File: rtl/comp_dict.sv
// comp_dict: append-only word dictionary with fill counter and parallel lowest-index match.
module comp_dict #(
    parameter int ADDR_W = comp_decomp_pkg::ADDR_W,
    parameter int DATA_W = comp_decomp_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic              wr_i,
    input  logic              flush_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] hit_idx_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic [ADDR_W-1:0] count_o
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   count_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else if (flush_i) count_q <= '0;
        else if (wr_i) count_q <= count_q + 1'b1;
    end
    // Contents need no reset: entries at or above count_q are never treated as valid.
    always_ff @(posedge clk) begin
        if (wr_i) mem_q[count_q[ADDR_W-1:0]] <= data_i;
    end
    always_comb begin
        hit_o = 1'b0;
        hit_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((ADDR_W+1)'(i) < count_q && mem_q[i] == data_i) begin
                hit_o = 1'b1;
                hit_idx_o = ADDR_W'(i);
            end
        end
    end
    assign rd_data_o  = mem_q[idx_i];
    assign rd_valid_o = {1'b0, idx_i} < count_q;
    assign full_o     = count_q[ADDR_W];
    assign count_o    = count_q[ADDR_W-1:0];
endmodule

// File: rtl/compression_decompression_core.sv
// compression_decompression_core: command decode and registered outputs around comp_dict.
// Define COMPRESSION_DECOMPRESSION_FLUSH_EN to make command 11 flush the dictionary.
module compression_decompression_core #(
    parameter int ADDR_W = comp_decomp_pkg::ADDR_W,
    parameter int DATA_W = comp_decomp_pkg::DATA_W
) (
    input logic   clk,
    input logic   reset,
    comp_if.slave bus
);
    import comp_decomp_pkg::*;
    logic              hit, rd_valid, full, wr, flush;
    logic [ADDR_W-1:0] hit_idx, count;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] comp_q, comp_d;
    logic [DATA_W-1:0] decomp_q, decomp_d;
    response_e         resp_q, resp_d;
    command_e          cmd;
    comp_dict #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dict (
        .clk(clk), .reset(reset), .data_i(bus.data_in), .idx_i(bus.compressed_in),
        .wr_i(wr), .flush_i(flush), .hit_o(hit), .hit_idx_o(hit_idx), .rd_data_o(rd_data),
        .rd_valid_o(rd_valid), .full_o(full), .count_o(count)
    );
    assign cmd = command_e'(bus.command);
    always_comb begin
        resp_d = RESP_IDLE;
        comp_d = comp_q;
        decomp_d = decomp_q;
        wr = 1'b0;
        flush = 1'b0;
        case (cmd)
            CMD_COMPRESS: begin
                wr = !hit && !full;
                comp_d = hit ? hit_idx : (full ? comp_q : count);
                resp_d = (hit || !full) ? RESP_COMP_OK : RESP_ERROR;
            end
            CMD_DECOMPRESS: begin
                decomp_d = rd_valid ? rd_data : decomp_q;
                resp_d = rd_valid ? RESP_DECOMP_OK : RESP_ERROR;
            end
            CMD_RSVD: begin
`ifdef COMPRESSION_DECOMPRESSION_FLUSH_EN
                flush = 1'b1;
`else
                resp_d = RESP_ERROR;
`endif
            end
            default: resp_d = RESP_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            comp_q <= '0;
            decomp_q <= '0;
            resp_q <= RESP_IDLE;
        end else begin
            comp_q <= comp_d;
            decomp_q <= decomp_d;
            resp_q <= resp_d;
        end
    end
    assign bus.compressed_out   = comp_q;
    assign bus.decompressed_out = decomp_q;
    assign bus.response         = resp_q;
endmodule

// File: tb/tb_compression_decompression_core.sv
// tb_compression_decompression_core: directed checks of compress/decompress, fill boundary, reset and command 11.
module tb_compression_decompression_core;
    localparam logic [79:0] W0 = 80'h0035_00000026_00000025;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    comp_if #(.ADDR_W(8), .DATA_W(80)) bus ();
    compression_decompression_core #(.ADDR_W(8), .DATA_W(80)) dut (.clk(clk), .reset(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic [1:0] cmd, input logic [79:0] din, input logic [7:0] cin);
        bus.command = cmd;
        bus.data_in = din;
        bus.compressed_in = cin;
        @(posedge clk);
        #1;
        bus.command = 2'b00;
    endtask
    task automatic expect_out(input string tag, input logic [1:0] resp, input logic [7:0] idx, input logic [79:0] word);
        chk({tag, "_resp"}, 80'(bus.response), 80'(resp));
        chk({tag, "_idx"}, 80'(bus.compressed_out), 80'(idx));
        chk({tag, "_data"}, bus.decompressed_out, word);
    endtask
    initial begin
        bus.command = 2'b00;
        bus.data_in = '0;
        bus.compressed_in = '0;
        #23;
        expect_out("reset", 2'b00, 8'h00, 80'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, W0, 8'h00);
        expect_out("comp_w0", 2'b01, 8'h00, 80'h0);
        step(2'b01, W0, 8'h00);
        expect_out("comp_w0_again", 2'b01, 8'h00, 80'h0);
        step(2'b01, 80'h1, 8'h00);
        expect_out("comp_one", 2'b01, 8'h01, 80'h0);
        step(2'b10, 80'h0, 8'h00);
        expect_out("decomp_0", 2'b10, 8'h01, W0);
        step(2'b10, 80'h0, 8'hF0);
        expect_out("decomp_f0", 2'b11, 8'h01, W0);
        step(2'b10, 80'h0, 8'h01);
        expect_out("decomp_1", 2'b10, 8'h01, 80'h1);
        step(2'b00, 80'h0, 8'h00);
        expect_out("nop", 2'b00, 8'h01, 80'h1);
        for (int i = 2; i < 256; i++) begin
            step(2'b01, 80'hA000 + 80'(i), 8'h00);
            chk("fill_resp", 80'(bus.response), 80'h1);
            chk("fill_idx", 80'(bus.compressed_out), 80'(i));
        end
        step(2'b01, 80'hFFFF, 8'h00);
        expect_out("full_new", 2'b11, 8'hFF, 80'h1);
        step(2'b01, 80'hA005, 8'h00);
        expect_out("full_repeat5", 2'b01, 8'h05, 80'h1);
        step(2'b01, W0, 8'h00);
        expect_out("full_repeat0", 2'b01, 8'h00, 80'h1);
        step(2'b10, 80'h0, 8'hFF);
        expect_out("decomp_ff", 2'b10, 8'h00, 80'hA0FF);
        #3;
        rst_n = 1'b0;
        #2;
        expect_out("midreset", 2'b00, 8'h00, 80'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, 80'h1, 8'h00);
        expect_out("post_reset_comp", 2'b01, 8'h00, 80'h0);
        step(2'b10, 80'h0, 8'h01);
        expect_out("post_reset_decomp1", 2'b11, 8'h00, 80'h0);
        step(2'b11, 80'h0, 8'h00);
`ifdef COMPRESSION_DECOMPRESSION_FLUSH_EN
        expect_out("flush", 2'b00, 8'h00, 80'h0);
        step(2'b10, 80'h0, 8'h00);
        expect_out("after_flush", 2'b11, 8'h00, 80'h0);
`else
        expect_out("illegal_cmd", 2'b11, 8'h00, 80'h0);
        step(2'b10, 80'h0, 8'h00);
        expect_out("after_illegal", 2'b10, 8'h00, 80'h1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
